// File: rtl/status_tx_reporter_if.sv
// rtl/status_tx_reporter_if.sv - UART rx/tx handshake bundle for the status reporter
interface status_tx_reporter_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic       frame_active;

  modport master (
    input  rx_data, new_rx_data, tx_busy,
    output tx_data, new_tx_data, frame_active
  );

  modport slave (
    output rx_data, new_rx_data, tx_busy,
    input  tx_data, new_tx_data, frame_active
  );
endinterface

// File: rtl/status_tx_reporter.sv
// rtl/status_tx_reporter.sv - ASCII status frame serialiser feeding uart_tx
module status_tx_reporter #(
  parameter int          AUTO_REPORT = 1,
  parameter int unsigned HOLDOFF     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  status_tx_reporter_if.master        bus,
  input  logic [5:0]                  tdc_enable,
  input  logic [5:0]                  soft_reset,
  input  logic                        pause,
  input  logic                        go_home
);

  localparam logic [15:0] HOLDOFF_LD = 16'(HOLDOFF);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_ACK, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic        ack_dly;
  logic        pending, pending_q, rst_seen;
  logic [7:0]  shadow;
  logic [5:0]  snap_en;
  logic        snap_pause, snap_gh, snap_rst;
  logic [15:0] holdoff_cnt;
  logic [7:0]  tx_data_r;
  logic [7:0]  frame_byte;
  logic [7:0]  status_now;
  logic        leave_idle, query, rst_rise, auto_trig;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign status_now = {tdc_enable, pause, go_home};
  assign leave_idle = (state == IDLE) && (state_nxt == LOAD);
  assign query      = bus.new_rx_data && (bus.rx_data == 8'h3F);
  // A strobe arriving while the snapshot clears rst_seen still counts as a fresh rise.
  assign rst_rise   = (|soft_reset) && (!rst_seen || leave_idle);
  assign auto_trig  = (AUTO_REPORT != 0) &&
                      (((status_now != shadow) && !leave_idle) || rst_rise);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pending && (pending_q || holdoff_cnt == 16'd0)) state_nxt = LOAD;
      LOAD:     state_nxt = STROBE;
      STROBE:   if (!bus.tx_busy) state_nxt = WAIT_ACK;
      WAIT_ACK: if (!ack_dly && !bus.tx_busy) state_nxt = (idx == 3'd4) ? DONE : LOAD;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_byte = 8'h53;
    case (idx)
      3'd1:    frame_byte = hex_char({2'b00, snap_en[5:4]});
      3'd2:    frame_byte = hex_char(snap_en[3:0]);
      3'd3:    frame_byte = hex_char({1'b0, snap_rst, snap_gh, snap_pause});
      3'd4:    frame_byte = 8'h0A;
      default: frame_byte = 8'h53;
    endcase
  end

  assign bus.tx_data      = tx_data_r;
  assign bus.new_tx_data  = (state == STROBE) && !bus.tx_busy;
  assign bus.frame_active = (state == LOAD) || (state == STROBE) || (state == WAIT_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      ack_dly     <= 1'b0;
      pending     <= 1'b0;
      pending_q   <= 1'b0;
      rst_seen    <= 1'b0;
      shadow      <= 8'h00;
      snap_en     <= 6'h00;
      snap_pause  <= 1'b0;
      snap_gh     <= 1'b0;
      snap_rst    <= 1'b0;
      holdoff_cnt <= 16'd0;
      tx_data_r   <= 8'h00;
    end else begin
      state     <= state_nxt;
      pending   <= (pending && !leave_idle) || query || auto_trig;
      pending_q <= (pending_q && !leave_idle) || query;
      rst_seen  <= (|soft_reset) || (rst_seen && !leave_idle);

      if (leave_idle) begin
        idx        <= 3'd0;
        snap_en    <= tdc_enable;
        snap_pause <= pause;
        snap_gh    <= go_home;
        snap_rst   <= rst_seen;
        shadow     <= status_now;
      end else if (state == WAIT_ACK && state_nxt == LOAD) begin
        idx <= idx + 3'd1;
      end

      if (state == LOAD) tx_data_r <= frame_byte;

      // uart_tx raises busy one cycle after the strobe, so skip that cycle.
      if (state == STROBE && !bus.tx_busy) ack_dly <= 1'b1;
      else if (state == WAIT_ACK)          ack_dly <= 1'b0;

      if (state == DONE)              holdoff_cnt <= HOLDOFF_LD;
      else if (holdoff_cnt != 16'd0)  holdoff_cnt <= holdoff_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_status_tx_reporter.sv
// tb/tb_status_tx_reporter.sv - scoreboard bench for status_tx_reporter
module tb_status_tx_reporter;
  localparam int HOLDOFF = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] tdc_enable, soft_reset;
  logic       pause, go_home;

  status_tx_reporter_if bus();

  status_tx_reporter #(.AUTO_REPORT(1), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tdc_enable(tdc_enable), .soft_reset(soft_reset),
    .pause(pause), .go_home(go_home)
  );

  always #5 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  longint     cyc = 0;
  logic [7:0] exp_q[$];
  int         strobes = 0;
  bit         model_rst = 1'b0;
  int         busy_len = 1;
  bit         rand_busy = 1'b0;
  bit         strobe_seen = 1'b0;
  int         busy_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic expect_frame(input logic [5:0] en, input bit p, input bit gh);
    int v;
    v = int'(en);
    exp_q.push_back(8'h53);
    exp_q.push_back(hexc(v / 16));
    exp_q.push_back(hexc(v % 16));
    exp_q.push_back(hexc(int'(model_rst) * 4 + int'(gh) * 2 + int'(p)));
    exp_q.push_back(8'h0A);
    model_rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expected byte per strobe.
  initial forever begin
    @(negedge clk);
    strobe_seen = 1'b0;
    if (!rst && bus.new_tx_data) begin
      strobe_seen = 1'b1;
      strobes++;
      check("busy_at_strobe", int'(bus.tx_busy), 0);
      check("active_at_strobe", int'(bus.frame_active), 1);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_byte: got %02h expected none", bus.tx_data);
      end else begin
        check("tx_byte", int'(bus.tx_data), int'(exp_q.pop_front()));
      end
    end
  end

  // uart_tx stand-in: busy from the cycle after an accepted strobe.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst)              busy_cnt = 0;
      else if (strobe_seen) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = (busy_cnt > 0) || (rand_busy && $urandom_range(0, 3) == 0);
    end
  end

  task automatic query(input logic [5:0] en, input bit p, input bit gh);
    @(negedge clk);
    tdc_enable = en; pause = p; go_home = gh;
    bus.rx_data = 8'h3F; bus.new_rx_data = 1'b1;
    @(negedge clk);
    bus.new_rx_data = 1'b0;
  endtask

  task automatic wait_quiet();
    int idle;
    idle = 0;
    for (int i = 0; i < 5000 && idle < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.frame_active) idle++;
      else idle = 0;
    end
    compared++;
    if (idle < 40) begin
      mismatched++;
      $display("FAIL quiet_timeout: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_active(input bit level);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (bus.frame_active == level) ok = 1'b1;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL frame_active_timeout: got %0b expected %0b", !level, level);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] en;
    bit         p, gh;
    int         kind, s0;
    longint     c0, c1;
    bit         ok;

    rst = 1'b1;
    tdc_enable = 6'h00; soft_reset = 6'h00; pause = 1'b0; go_home = 1'b0;
    bus.rx_data = 8'h00; bus.new_rx_data = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_data", int'(bus.tx_data), 0);
    check("reset_new_tx_data", int'(bus.new_tx_data), 0);
    check("reset_frame_active", int'(bus.frame_active), 0);
    rst = 1'b0;
    wait_quiet();

    query(6'h00, 1'b0, 1'b0);
    expect_frame(6'h00, 1'b0, 1'b0);
    wait_quiet();

    @(negedge clk);
    tdc_enable = 6'h3F;
    expect_frame(6'h3F, 1'b0, 1'b0);
    wait_quiet();

    @(negedge clk);
    soft_reset = 6'h01; pause = 1'b1; model_rst = 1'b1;
    expect_frame(6'h3F, 1'b1, 1'b0);
    @(negedge clk);
    soft_reset = 6'h00;
    wait_quiet();
    query(6'h3F, 1'b1, 1'b0);
    expect_frame(6'h3F, 1'b1, 1'b0);
    wait_quiet();

    busy_len = 100;
    query(6'h1C, 1'b0, 1'b1);
    expect_frame(6'h1C, 1'b0, 1'b1);
    wait_quiet();

    busy_len = 6;
    query(6'h05, 1'b0, 1'b1);
    expect_frame(6'h05, 1'b0, 1'b1);
    wait_active(1'b1);
    repeat (3) @(negedge clk);
    query(6'h2A, 1'b1, 1'b0);
    expect_frame(6'h2A, 1'b1, 1'b0);
    wait_quiet();

    busy_len = 2;
    query(6'h11, 1'b0, 1'b0);
    expect_frame(6'h11, 1'b0, 1'b0);
    wait_active(1'b1);
    wait_active(1'b0);
    c0 = cyc;
    tdc_enable = 6'h12;
    expect_frame(6'h12, 1'b0, 1'b0);
    ok = 1'b0;
    c1 = c0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (bus.new_tx_data) begin ok = 1'b1; c1 = cyc; end
    end
    check("auto_frame_started", int'(ok), 1);
    compared++;
    if (c1 - c0 < HOLDOFF) begin
      mismatched++;
      $display("FAIL holdoff_gap: got %0d cycles expected >= %0d", c1 - c0, HOLDOFF);
    end
    wait_quiet();

    for (int it = 0; it < 12; it++) begin
      en = 6'($urandom_range(0, 63));
      p  = 1'($urandom_range(0, 1));
      gh = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      busy_len = $urandom_range(1, 8);
      rand_busy = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            bus.rx_data = 8'($urandom_range(0, 62)); bus.new_rx_data = 1'b1;
            @(negedge clk);
            bus.new_rx_data = 1'b0;
          end
          query(en, p, gh);
          expect_frame(en, p, gh);
        end
        1: begin
          if ({en, p, gh} == {tdc_enable, pause, go_home}) en = en ^ 6'h01;
          @(negedge clk);
          tdc_enable = en; pause = p; go_home = gh;
          expect_frame(en, p, gh);
        end
        default: begin
          @(negedge clk);
          soft_reset = 6'($urandom_range(1, 63));
          tdc_enable = en; pause = p; go_home = gh;
          model_rst = 1'b1;
          expect_frame(en, p, gh);
          @(negedge clk);
          soft_reset = 6'h00;
        end
      endcase
      wait_quiet();
    end

    rand_busy = 1'b0;
    busy_len = 3;
    query(6'h00, 1'b0, 1'b0);
    expect_frame(6'h00, 1'b0, 1'b0);
    wait_quiet();
    s0 = strobes;
    query(6'h00, 1'b0, 1'b0);
    exp_q.push_back(8'h53);
    exp_q.push_back(hexc(0));
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (strobes >= s0 + 2) ok = 1'b1;
    end
    check("two_bytes_before_reset", int'(ok), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midframe_rst_new_tx_data", int'(bus.new_tx_data), 0);
    check("midframe_rst_frame_active", int'(bus.frame_active), 0);
    check("midframe_rst_tx_data", int'(bus.tx_data), 0);
    check("partial_frame_bytes_left", exp_q.size(), 0);
    exp_q.delete();
    model_rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_quiet();
    query(6'h27, 1'b1, 1'b1);
    expect_frame(6'h27, 1'b1, 1'b1);
    wait_quiet();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
